// File: rtl/paralelo_serial_pkg.sv
// Constants and state encoding shared by the parallel-to-serial transmitter
// and its serial-to-parallel receiver neighbour.
package paralelo_serial_pkg;

    localparam int SYM_W = 8;
    localparam logic [SYM_W-1:0] PS_COMMA = 8'hBC;

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } ps_state_e;

    // Symbol for the next load boundary: the held byte goes first, then a
    // byte that is being transferred in the same cycle, then the idle comma.
    function automatic logic [SYM_W-1:0] pick_symbol(
        input logic             hold_full,
        input logic [SYM_W-1:0] hold_data,
        input logic             xfer,
        input logic [SYM_W-1:0] data_in,
        input logic [SYM_W-1:0] comma
    );
        if (hold_full)
            return hold_data;
        else if (xfer)
            return data_in;
        else
            return comma;
    endfunction

endpackage

// File: rtl/paralelo_serial_shifter.sv
// Symbol shift register and bit counter; the MSB of shreg is the wire bit.
// The register reloads at bit position 7 and otherwise shifts left.
module ps_shifter
    import paralelo_serial_pkg::*;
#(
    parameter logic [SYM_W-1:0] RESET_SYM = PS_COMMA
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [SYM_W-1:0] load_sym,
    output logic             boundary,
    output logic             bit_out
);

    logic [SYM_W-1:0] shreg;
    logic [2:0]       bit_cnt;

    assign boundary = (bit_cnt == 3'd7);
    assign bit_out  = shreg[SYM_W-1];

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            shreg   <= RESET_SYM;
            bit_cnt <= 3'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (boundary)
                shreg <= load_sym;
            else
                shreg <= {shreg[SYM_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: bytes in over valid/ready, MSB-first bits out,
// commas filling idle symbols, and a comma training burst after reset.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter logic [SYM_W-1:0] COMMA   = PS_COMMA,
    parameter int               N_TRAIN = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [SYM_W-1:0] data_in_PS,
    input  logic             valid_in_PS,
    output logic             ready_PS,
    output logic             data_out_PS,
    output logic             active_PS
);

    ps_state_e        state_q, state_d;
    logic [3:0]       comma_cnt_q, comma_cnt_d;
    logic [SYM_W-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;
    logic             boundary;
    logic             xfer;
    logic [SYM_W-1:0] load_sym;

    // Ready depends on registers only, so an upstream valid cannot loop back.
    assign ready_PS  = (state_q == ACTIVE) && !hold_full_q;
    assign active_PS = (state_q == ACTIVE);
    assign xfer      = valid_in_PS && ready_PS;
    assign load_sym  = pick_symbol(hold_full_q, hold_data_q, xfer, data_in_PS, COMMA);

    ps_shifter #(
        .RESET_SYM (COMMA)
    ) u_shifter (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load_sym (load_sym),
        .boundary (boundary),
        .bit_out  (data_out_PS)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= TRAIN;
            comma_cnt_q <= 4'd0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

    // The comma loaded at reset is training comma 0, so the switch to ACTIVE
    // happens on the boundary that ends comma N_TRAIN-1.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        if (state_q == TRAIN && boundary) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q == 4'(N_TRAIN - 1))
                state_d = ACTIVE;
        end
    end

    // Hold buffer: fill on a mid-symbol transfer, drain at the boundary.
    // A boundary transfer bypasses straight into the shifter.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        if (boundary) begin
            hold_full_d = 1'b0;
        end else if (xfer) begin
            hold_data_d = data_in_PS;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial against a queue-based symbol-stream
// model: accepted bytes wait in a FIFO and each 8-cycle slot carries one of them or a comma.
module tb_paralelo_serial;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam int         N_TRAIN   = 4;
    localparam int         TRAIN_CYC = 8 * N_TRAIN;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in_PS;
    logic       valid_in_PS;
    logic       ready_PS;
    logic       data_out_PS;
    logic       active_PS;

    int checks   = 0;
    int failures = 0;

    int         cyc;
    logic [7:0] pend[$];
    bit         bitq[$];

    paralelo_serial #(
        .COMMA   (COMMA),
        .N_TRAIN (N_TRAIN)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in_PS  (data_in_PS),
        .valid_in_PS (valid_in_PS),
        .ready_PS    (ready_PS),
        .data_out_PS (data_out_PS),
        .active_PS   (active_PS)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic push_symbol(input logic [7:0] sym);
        for (int i = 7; i >= 0; i--) bitq.push_back(sym[i]);
    endtask

    task automatic model_reset();
        cyc = 0;
        pend.delete();
        bitq.delete();
        push_symbol(COMMA);
    endtask

    // Compare the current outputs with the model, then drive one clock cycle.
    task automatic step(input logic v, input logic [7:0] d, output logic x);
        logic exp_act, exp_rdy, exp_bit;
        logic [7:0] sym;
        exp_act = (cyc >= TRAIN_CYC);
        exp_rdy = exp_act && (pend.size() == 0);
        exp_bit = bitq[0];
        checks += 3;
        if (data_out_PS !== exp_bit) begin
            failures++;
            $display("FAIL wire_bit cyc=%0d got=%b exp=%b", cyc, data_out_PS, exp_bit);
        end
        if (ready_PS !== exp_rdy) begin
            failures++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready_PS, exp_rdy);
        end
        if (active_PS !== exp_act) begin
            failures++;
            $display("FAIL active cyc=%0d got=%b exp=%b", cyc, active_PS, exp_act);
        end
        valid_in_PS = v;
        data_in_PS  = d;
        x = v && exp_rdy;
        if (x) pend.push_back(d);
        @(posedge clk_32f);
        #1;
        void'(bitq.pop_front());
        cyc++;
        if (cyc % 8 == 0) begin
            sym = (pend.size() != 0) ? pend.pop_front() : COMMA;
            push_symbol(sym);
        end
    endtask

    task automatic idle(input int n);
        logic x;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), x);
    endtask

    task automatic wait_pos(input int p);
        logic x;
        for (int i = 0; i < 8 && (cyc % 8) != p; i++) step(1'b0, 8'h00, x);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (data_out_PS !== 1'b1 || ready_PS !== 1'b0 || active_PS !== 1'b0) begin
            failures++;
            $display("FAIL %s got out/rdy/act=%b%b%b exp=100", name,
                     data_out_PS, ready_PS, active_PS);
        end
    endtask

    // Reset asserted between edges; released #1 after an edge so cycle 0 starts cleanly.
    task automatic apply_reset(input string name);
        reset       = 1'b1;
        valid_in_PS = 1'b0;
        #1;
        check_reset_outputs(name);
        @(posedge clk_32f);
        #1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int first_act;
        logic x;
        apply_reset("reset_state");
        first_act = -1;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 8'h00, x);
            if (active_PS === 1'b1 && first_act < 0) first_act = cyc;
        end
        checks++;
        if (first_act != TRAIN_CYC) begin
            failures++;
            $display("FAIL active_rise got=%0d exp=%0d", first_act, TRAIN_CYC);
        end
        // Valid held high during training must not be accepted.
        apply_reset("reset_state_2");
        for (int i = 0; i < TRAIN_CYC + 16; i++) step(i < TRAIN_CYC, 8'($urandom), x);
    endtask

    task automatic test_single();
        logic x;
        wait_pos(3);
        step(1'b1, 8'hA5, x);
        checks++;
        if (ready_PS !== 1'b0) begin
            failures++;
            $display("FAIL single_hold_ready got=%b exp=0", ready_PS);
        end
        idle(24);
    endtask

    task automatic test_bypass();
        logic x;
        wait_pos(7);
        step(1'b1, 8'h3C, x);
        checks += 2;
        if (ready_PS !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ready got=%b exp=1", ready_PS);
        end
        if (data_out_PS !== 1'b0) begin
            failures++;
            $display("FAIL bypass_first_bit got=%b exp=0", data_out_PS);
        end
        idle(16);
    endtask

    task automatic test_stream();
        logic [7:0] seq [4];
        int idx, dut_xfers;
        logic x;
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'hFF; seq[3] = 8'h00;
        idx = 0;
        dut_xfers = 0;
        wait_pos(0);
        for (int i = 0; i < 40; i++) begin
            if (idx < 4 && ready_PS === 1'b1) dut_xfers++;
            step(idx < 4, (idx < 4) ? seq[idx] : 8'h00, x);
            if (x) idx++;
        end
        checks++;
        if (dut_xfers != 4) begin
            failures++;
            $display("FAIL stream_xfers got=%0d exp=4", dut_xfers);
        end
        idle(16);
    endtask

    task automatic test_gap();
        logic x;
        x = 1'b0;
        for (int i = 0; i < 16 && !x; i++) step(1'b1, 8'h55, x);
        idle(20);
        x = 1'b0;
        for (int i = 0; i < 16 && !x; i++) step(1'b1, 8'hAA, x);
        idle(24);
    endtask

    task automatic test_midreset();
        int n;
        logic x;
        wait_pos(2);
        step(1'b1, 8'($urandom), x);
        step(1'b0, 8'h00, x);
        checks++;
        if (ready_PS !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hold_ready got=%b exp=0", ready_PS);
        end
        apply_reset("midrst_immediate");
        n = 0;
        while (ready_PS !== 1'b1 && n < 100) begin
            step(1'b0, 8'h00, x);
            n++;
        end
        checks++;
        if (n != TRAIN_CYC) begin
            failures++;
            $display("FAIL midrst_retrain got=%0d exp=%0d", n, TRAIN_CYC);
        end
        idle(8);
    endtask

    task automatic test_random();
        logic x;
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), x);
        idle(24);
    endtask

    initial begin
        reset       = 1'b1;
        valid_in_PS = 1'b0;
        data_in_PS  = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_bypass();
        test_stream();
        test_gap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
